// File: rtl/if_id_fetch_if.sv
// rtl/if_id_fetch_if.sv - instruction memory bus and IF/ID output bundle for if_id_fetch
interface if_id_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic [4:0]  if_rs1;
    logic [4:0]  if_rs2;
    logic [4:0]  if_rd;

    // Fetch stage side: issues requests, owns the IF/ID register
    modport master (
        output imem_req, imem_addr, if_pc, if_instr, if_valid, if_rs1, if_rs2, if_rd,
        input  imem_ack, imem_rdata
    );

    // Memory / decode side
    modport slave (
        input  imem_req, imem_addr, if_pc, if_instr, if_valid, if_rs1, if_rs2, if_rd,
        output imem_ack, imem_rdata
    );
endinterface

// File: rtl/if_id_fetch.sv
// rtl/if_id_fetch.sv - fetch stage with IF/ID register, one-entry stall buffer, optional perf counters (FETCH_PERF_EN)
module if_id_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt,
`endif
    if_id_fetch_if.master bus
);

    typedef enum logic [1:0] {REQ, DRAIN, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pc_reg, pc_n;
    logic [31:0] redir_pc, redir_n;
    logic [31:0] buf_pc, buf_pc_n;
    logic [31:0] buf_instr, buf_instr_n;
    logic [31:0] if_pc, if_pc_n;
    logic [31:0] if_instr, if_instr_n;
    logic        if_valid, if_valid_n;
    logic        capture;
    logic        flush;

    // While ID is stalled with a buffered instruction there is nowhere to put another one
    assign bus.imem_req  = !rst && (state != HOLD);
    assign bus.imem_addr = pc_reg;
    assign bus.if_pc     = if_pc;
    assign bus.if_instr  = if_instr;
    assign bus.if_valid  = if_valid;
    assign bus.if_rs1    = if_instr[19:15];
    assign bus.if_rs2    = if_instr[24:20];
    assign bus.if_rd     = if_instr[11:7];

    // Next-state and next-register values; capture marks an ack whose data is kept
    always_comb begin
        state_n     = state;
        pc_n        = pc_reg;
        redir_n     = redir_pc;
        buf_pc_n    = buf_pc;
        buf_instr_n = buf_instr;
        if_pc_n     = if_pc;
        if_instr_n  = if_instr;
        if_valid_n  = if_valid;
        capture     = 1'b0;
        flush       = 1'b0;
        case (state)
            REQ: begin
                if (redirect) begin
                    flush = 1'b1;
                    if (bus.imem_ack) begin
                        pc_n = redirect_pc;
                    end else begin
                        // The outstanding request must complete before the new address is issued
                        redir_n = redirect_pc;
                        state_n = DRAIN;
                    end
                end else if (bus.imem_ack) begin
                    capture = 1'b1;
                    pc_n    = pc_reg + 32'd4;
                    if (stall) begin
                        buf_pc_n    = pc_reg;
                        buf_instr_n = bus.imem_rdata;
                        state_n     = HOLD;
                    end else begin
                        if_pc_n    = pc_reg;
                        if_instr_n = bus.imem_rdata;
                        if_valid_n = 1'b1;
                    end
                end else if (!stall) begin
                    flush = 1'b1;
                end
            end
            DRAIN: begin
                flush = 1'b1;
                if (redirect) begin
                    redir_n = redirect_pc;
                end
                if (bus.imem_ack) begin
                    pc_n    = redirect ? redirect_pc : redir_pc;
                    state_n = REQ;
                end
            end
            HOLD: begin
                if (redirect) begin
                    flush   = 1'b1;
                    pc_n    = redirect_pc;
                    state_n = REQ;
                end else if (!stall) begin
                    if_pc_n    = buf_pc;
                    if_instr_n = buf_instr;
                    if_valid_n = 1'b1;
                    state_n    = REQ;
                end
            end
            default: state_n = REQ;
        endcase
        if (flush) begin
            if_valid_n = 1'b0;
            if_instr_n = NOP_INSTR;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REQ;
            pc_reg    <= RESET_PC;
            redir_pc  <= 32'd0;
            buf_pc    <= 32'd0;
            buf_instr <= 32'd0;
            if_pc     <= 32'd0;
            if_instr  <= NOP_INSTR;
            if_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            pc_reg    <= pc_n;
            redir_pc  <= redir_n;
            buf_pc    <= buf_pc_n;
            buf_instr <= buf_instr_n;
            if_pc     <= if_pc_n;
            if_instr  <= if_instr_n;
            if_valid  <= if_valid_n;
        end
    end

`ifdef FETCH_PERF_EN
    // Kept fetches and bubble writes into IF/ID, free-running and wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt  <= 32'd0;
            perf_bubble_cnt <= 32'd0;
        end else begin
            if (capture) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (flush)   perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: doc/if_id_fetch.md
Name: if_id_fetch

Overview:
Instruction fetch stage plus IF/ID pipeline register that feeds the ID stage, which in turn drives the ID/EX register. It owns the PC, issues requests to a variable-latency instruction memory with a req/ack handshake, and presents the registered PC, instruction and decoded register indices to ID. It honours a stall from the hazard unit and a taken-branch/jump redirect from EX. A one-entry buffer holds any instruction that returns while ID is stalled.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, instruction word presented when IF/ID is invalid (addi x0,x0,0)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
stall  in  1  hazard unit: hold IF/ID contents
redirect  in  1  EX: taken branch/jump, flush and refetch
redirect_pc  in  32  target PC, valid with redirect
imem_req  out  1  fetch request
imem_addr  out  32  fetch address
imem_ack  in  1  instruction returned this cycle
imem_rdata  in  32  instruction word, valid with imem_ack
if_pc  out  32  PC of the instruction in IF/ID
if_instr  out  32  instruction in IF/ID
if_valid  out  1  IF/ID holds a real instruction
if_rs1  out  5  if_instr[19:15]
if_rs2  out  5  if_instr[24:20]
if_rd  out  5  if_instr[11:7]

Behaviour:
- Reset, asynchronous: pc_reg=RESET_PC, state=REQ, if_pc=0, if_instr=NOP_INSTR, if_valid=0, buffer empty, redir_pc=0. imem_req is forced to 0 while rst=1.
- imem_req=1 in REQ and DRAIN, 0 in HOLD. imem_addr=pc_reg.
- Memory protocol: imem_addr stays stable while imem_req=1 until imem_ack. Data arrives in the ack cycle, with minimum latency of 0 cycles.
- State REQ:
  - ack & !stall & !redirect: IF/ID <= {pc_reg, rdata, valid=1}; pc_reg += 4 (mod 2^32); stay in REQ.
  - ack & stall & !redirect: buffer <= {pc_reg, rdata}; pc_reg += 4; go to HOLD. IF/ID is unchanged.
  - !ack & !stall & !redirect: IF/ID valid <= 0 and instr <= NOP_INSTR (bubble). pc_reg is unchanged.
  - !ack & stall: IF/ID is unchanged.
  - redirect & ack: discard rdata; flush IF/ID (valid=0, NOP); pc_reg <= redirect_pc; stay in REQ.
  - redirect & !ack: flush IF/ID; redir_pc <= redirect_pc; go to DRAIN.
- State DRAIN: keeps the old address with imem_req=1.
  - IF/ID stays flushed.
  - A new redirect overwrites redir_pc; the latest one wins.
  - On ack: discard rdata; pc_reg <= redir_pc, or redirect_pc if redirect is high in the same cycle; go to REQ.
- State HOLD:
  - !stall & !redirect: IF/ID <= {buffer, valid=1}; go to REQ.
  - stall: hold.
  - redirect: drop buffer; flush IF/ID; pc_reg <= redirect_pc; go to REQ.
- Priority: rst > redirect > stall. A redirect always flushes IF/ID, even when stall is high.
- if_rs1, if_rs2 and if_rd are combinational slices of registered if_instr. They read 0 when the slot holds NOP_INSTR.
- Throughput: with 0-latency memory and no stall, one instruction per cycle. The first valid IF/ID is one cycle after rst deasserts.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds ports perf_fetch_cnt (out 32) and perf_bubble_cnt (out 32), both reset to 0 and wrapping at 2^32.
  - perf_fetch_cnt increments on every imem_ack in REQ that is not discarded.
  - perf_bubble_cnt increments on every cycle where IF/ID is written with valid=0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with ack always high and no stall: deassert rst → if_pc = 0, 4, 8 on successive cycles, if_valid=1 from the first cycle after reset, imem_addr leading if_pc by one cycle.
- Memory latency 2 (ack every third cycle) from PC 0x100 → if_valid pattern 0,0,1 repeating; if_pc = 0x100, then 0x104; perf_bubble_cnt=2 per instruction when FETCH_PERF_EN is defined.
- stall=1 held 3 cycles while ack returns instr 0x00A00093 at PC 0x8 → state HOLD, imem_req=0, IF/ID unchanged; after stall drops, if_instr=0x00A00093, if_pc=0x8, if_rd=1, next imem_addr=0xC.
- redirect to 0x200 coinciding with ack → if_valid=0 next cycle, imem_addr=0x200; the following ack yields if_pc=0x200.
- redirect to 0x300 then 0x400 while a request to 0x10 is outstanding (ack 3 cycles later) → imem_addr stays 0x10 until ack, then becomes 0x400; no instruction from 0x10 is ever valid.
- Assert rst mid-DRAIN and mid-HOLD → all outputs return immediately to reset values, imem_req=0, buffer discarded; after release, fetch restarts at RESET_PC.
